// File: rtl/ff_fault_sequencer_if.sv
// rtl/ff_fault_sequencer_if.sv - register bank connection between the fault sequencer and the bank under test
//
// Signals:
//   en : bank write enable (driven by the sequencer)
//   d  : bank data input   (driven by the sequencer)
//   q  : bank data output  (driven by the bank)
// Modports:
//   master : sequencer side
//   slave  : register bank side
interface ff_fault_sequencer_if #(
    parameter int N = 8
);
    logic         en;
    logic [N-1:0] d;
    logic [N-1:0] q;

    modport master (output en, output d, input q);
    modport slave  (input en, input d, output q);
endinterface

// File: rtl/ff_fault_sequencer.sv
// rtl/ff_fault_sequencer.sv - one laser fault-injection trial on the d_flipflop register bank
//
// Loads a pattern into the bank, holds it while pulsing the laser trigger, then
// reads the bank back and reports which bits flipped.
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   start        : begin a trial (only honoured in IDLE)
//   clear_total  : zero fault_total (wins over a same-cycle increment)
//   pattern      : test pattern, captured when start is accepted
//   bank         : register bank connection (en, d out; q in)
//   trig_out     : laser trigger, high in the first HOLD cycle
//   busy         : trial in progress
//   done         : one-cycle pulse when results are valid
//   fault        : last trial had at least one flipped bit
//   flip_mask    : q XOR expected from the last trial
//   flip_count   : number of set bits in flip_mask
//   fault_total  : saturating count of faulted trials
//
// Optional build macro ALT_PATTERN_EN: every second trial after reset uses
// ~pattern, so both rising and falling upsets are exercised.
module ff_fault_sequencer #(
    parameter int N           = 8,
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     clear_total,
    input  logic [N-1:0]             pattern,
    ff_fault_sequencer_if.master     bank,
    output logic                     trig_out,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output logic [N-1:0]             flip_mask,
    output logic [$clog2(N+1)-1:0]   flip_count,
    output logic [CNT_W-1:0]         fault_total
);
    localparam int CW = $clog2(N + 1);
    localparam int HW = 20;

    typedef logic [HW-1:0] hold_t;
    localparam hold_t HOLD_LAST = hold_t'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        HOLD   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] expected;
    hold_t        hold_cnt;
    logic [N-1:0] mask_now;
    logic         accept;

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    assign mask_now = bank.q ^ expected;
    assign accept   = (state == IDLE) && start;

    always_comb begin
        state_next = state;
        bank.en    = 1'b0;
        bank.d     = expected;
        trig_out   = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE:   if (start) state_next = LOAD;
            LOAD: begin
                bank.en    = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: state_next = HOLD;
            HOLD: begin
                trig_out = (hold_cnt == '0);
                if (hold_cnt == HOLD_LAST) state_next = CHECK;
            end
            CHECK:  state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ALT_PATTERN_EN
    // Toggles on every completed trial; selects the inverted pattern when set.
    logic phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= 1'b0;
        end else if (state == DONE) begin
            phase <= ~phase;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            expected <= '0;
            hold_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
`ifdef ALT_PATTERN_EN
                expected <= phase ? ~pattern : pattern;
`else
                expected <= pattern;
`endif
            end
            if (state == SETTLE) begin
                hold_cnt <= '0;
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt + hold_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flip_mask  <= '0;
            flip_count <= '0;
            fault      <= 1'b0;
        end else if (state == CHECK) begin
            flip_mask  <= mask_now;
            flip_count <= popcount(mask_now);
            fault      <= (mask_now != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_total) begin
            fault_total <= '0;
        end else if ((state == CHECK) && (mask_now != '0) && !(&fault_total)) begin
            fault_total <= fault_total + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ff_fault_sequencer.sv
// tb/tb_ff_fault_sequencer.sv - randomized self-checking bench for ff_fault_sequencer
module tb_ff_fault_sequencer;
    localparam int N     = 8;
    localparam int H     = 4;
    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         clear_total = 1'b0;
    logic [N-1:0] pattern = '0;
    logic         trig_out, busy, done, fault;
    logic [N-1:0] flip_mask;
    logic [3:0]   flip_count;
    logic [CNT_W-1:0] fault_total;

    logic [N-1:0] bank_reg = '0;
    logic [N-1:0] inj = '0;

    ff_fault_sequencer_if #(.N(N)) bank ();

    ff_fault_sequencer #(.N(N), .HOLD_CYCLES(H), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .clear_total(clear_total),
        .pattern(pattern), .bank(bank), .trig_out(trig_out), .busy(busy),
        .done(done), .fault(fault), .flip_mask(flip_mask),
        .flip_count(flip_count), .fault_total(fault_total)
    );

    always #5 clk = ~clk;

    // Behavioural register bank with an injectable upset mask on its output.
    always @(posedge clk) if (bank.en) bank_reg <= bank.d;
    assign bank.q = bank_reg ^ inj;

    int checks = 0;
    int errors = 0;
    int m_total = 0;
    int m_trial = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model_expected(input logic [N-1:0] pat);
`ifdef ALT_PATTERN_EN
        if (m_trial % 2 == 1) return ~pat;
`endif
        return pat;
    endfunction

    task automatic check_idle_results(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_trig"}, 32'(trig_out), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_en"}, 32'(bank.en), 0);
        check({tag, "_d"}, 32'(bank.d), 0);
        check({tag, "_mask"}, 32'(flip_mask), 0);
        check({tag, "_cnt"}, 32'(flip_count), 0);
        check({tag, "_fault"}, 32'(fault), 0);
        check({tag, "_total"}, 32'(fault_total), 0);
    endtask

    // One full trial; k counts negedges after the accepting edge (k=1 is LOAD).
    task automatic run_trial(input logic [N-1:0] pat, input logic [N-1:0] injm,
                             input bit clr, input bit stray);
        logic [N-1:0] expv;
        int dones;
        expv  = model_expected(pat);
        dones = 0;
        @(negedge clk);
        start   = 1'b1;
        pattern = pat;
        for (int k = 1; k <= H + 4; k++) begin
            @(negedge clk);
            start       = 1'b0;
            pattern     = N'($urandom);
            clear_total = 1'b0;
            if (done) dones++;
            check("en", 32'(bank.en), 32'(k == 1));
            check("trig", 32'(trig_out), 32'(k == 3));
            check("done", 32'(done), 32'(k == H + 4));
            check("busy", 32'(busy), 1);
            if (k == 1) check("ff_d", 32'(bank.d), 32'(expv));
            if (k == 3) inj = injm;
            if (stray && (k == 2 || k == 6)) start = 1'b1;
            if (clr && k == H + 3) clear_total = 1'b1;
            if (k == H + 4) begin
                if (clr) m_total = 0;
                else if (injm != 0 && m_total < SAT) m_total++;
                check("mask", 32'(flip_mask), 32'(injm));
                check("count", 32'(flip_count), $countones(injm));
                check("fault", 32'(fault), 32'(injm != 0));
                check("total", 32'(fault_total), m_total);
            end
        end
        @(negedge clk);
        inj = '0;
        check("busy_end", 32'(busy), 0);
        check("done_end", 32'(done), 0);
        check("one_done", dones, 1);
        m_trial++;
    endtask

    task automatic reset_mid_hold(input logic [N-1:0] pat);
        @(negedge clk);
        start   = 1'b1;
        pattern = pat;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) inj = 8'h10;
        end
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        inj     = '0;
        m_total = 0;
        m_trial = 0;
        check_idle_results("rst_mid");
        for (int k = 0; k < H + 6; k++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 0);
            check("rst_no_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_results("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_results("post_reset");

        run_trial(8'hA5, 8'h00, 0, 0);
        run_trial(8'hA5, 8'h01, 0, 0);
        run_trial(8'hA5, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++) run_trial(8'hA5, 8'hFF, 0, 0);
        run_trial(8'hA5, 8'h01, 1, 1);
        reset_mid_hold(8'h3C);
        run_trial(8'h0F, 8'h00, 0, 0);
        run_trial(8'h0F, 8'h00, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        m_total = 0;
        m_trial = 0;
        run_trial(8'h0F, 8'h02, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] p;
            logic [N-1:0] m;
            p = N'($urandom);
            m = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            run_trial(p, m, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
